led_code_scheduler: RTL and testbench

//  Shares one board LED between N_REQ requesters, each asking to flash a blink code (1..15 pulses).

---
 rtl/led_pkg.sv | 23 ++
 rtl/led_code_scheduler_if.sv | 16 +
 rtl/tick_gen.sv | 28 ++
 rtl/led_code_scheduler.sv | 151 +++++++++++++++
 tb/tb_led_code_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared LED-block definitions: sequencer state encoding and default timing.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_t;

  localparam int unsigned CODE_W_DEF    = 4;
  localparam int unsigned ON_TICKS_DEF  = 2;
  localparam int unsigned OFF_TICKS_DEF = 3;
  localparam int unsigned GAP_TICKS_DEF = 10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_code_scheduler_if.sv
// Request/grant/LED bundle between status sources and the blink-code scheduler.
interface led_code_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned CODE_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*CODE_W-1:0] code;
  logic                    idle_led;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic                    led;

  modport master (output req, code, idle_led, input grant, done, busy, led);
  modport slave  (input req, code, idle_led, output grant, done, busy, led);
endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CNT_W = $clog2(DIV);

  if (DIV < 2) begin : g_div_check
    $error("tick_gen: DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/led_code_scheduler.sv
// Round-robin shares one LED between requesters, flashing each one's blink code in turn.
module led_code_scheduler
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned CODE_W    = CODE_W_DEF,
  parameter int unsigned ON_TICKS  = ON_TICKS_DEF,
  parameter int unsigned OFF_TICKS = OFF_TICKS_DEF,
  parameter int unsigned GAP_TICKS = GAP_TICKS_DEF
) (
  input logic                 CLK100MHZ,
  input logic                 rst,
  led_code_scheduler_if.slave bus
);
  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PH_W  = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

  led_state_t        state;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  done;
  logic              busy;
  logic              led;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  sel_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              sel_valid;
  logic [CODE_W-1:0] sel_code;
  logic [CODE_W-1:0] pulses_left;
  logic [PH_W-1:0]   phase;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;

  assign bus.grant = grant;
  assign bus.done  = done;
  assign bus.busy  = busy;
  assign bus.led   = led;

  // First requester at or after rr_ptr, scanning with wrap-around.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr) + k) % N_REQ);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_code = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) sel_code = bus.code[i*CODE_W +: CODE_W];
    end
  end

  assign next_ptr = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
  assign tick_en  = (state != ST_IDLE);
  assign tick_clr = (state == ST_IDLE) && sel_valid;

  tick_gen #(.DIV(DIV)) u_tick (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .en        (tick_en),
    .clr       (tick_clr),
    .tick      (tick)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      led         <= 1'b0;
      rr_ptr      <= '0;
      pulses_left <= '0;
      phase       <= '0;
    end else begin
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          led <= bus.idle_led;
          if (sel_valid) begin
            grant       <= N_REQ'(1) << sel_idx;
            pulses_left <= sel_code;
            rr_ptr      <= next_ptr;
            phase       <= '0;
            busy        <= 1'b1;
            // A zero code still occupies the LED for one gap, just without pulses.
            if (sel_code == '0) begin
              state <= ST_GAP;
              led   <= 1'b0;
            end else begin
              state <= ST_ON;
              led   <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (tick) begin
            if (phase == PH_W'(ON_TICKS - 1)) begin
              phase <= '0;
              state <= ST_OFF;
              led   <= 1'b0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (phase == PH_W'(OFF_TICKS - 1)) begin
              phase       <= '0;
              pulses_left <= pulses_left - CODE_W'(1);
              if (pulses_left == CODE_W'(1)) begin
                state <= ST_GAP;
              end else begin
                state <= ST_ON;
                led   <= 1'b1;
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (phase == PH_W'(GAP_TICKS - 1)) begin
              phase <= '0;
              state <= ST_IDLE;
              done  <= grant;
              grant <= '0;
              busy  <= 1'b0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_code_scheduler.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor checks what the LED does.
module tb_led_code_scheduler;
  localparam int N     = 4;
  localparam int CW    = 4;
  localparam int DIV   = 10;
  localparam int ON    = 2;
  localparam int OFF   = 3;
  localparam int GAP   = 10;
  localparam int PULSE = (ON + OFF) * DIV;

  typedef struct {
    int idx;
    int code;
    int pre;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_code_scheduler_if #(.N_REQ(N), .CODE_W(CW)) bus ();

  led_code_scheduler #(
    .CLK_HZ(10), .TICK_HZ(1), .N_REQ(N), .CODE_W(CW),
    .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus.slave)
  );

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   model_ptr = 0;
  int   codes[N];
  bit   end_req = 0;
  bit   mon_fin = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (((mask >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
    return -1;
  endfunction

  // Monitor: outputs seen at a negedge come from the posedge just before it.
  logic [N-1:0] p_grant = '0;
  logic [N-1:0] p_done  = '0;
  logic         p_rst   = 1'b1;
  logic         p_idle  = 1'b0;
  int           zero_run = 0;
  bit           in_g = 0;
  exp_t         cur;
  int           glen, led_err, busy_err;
  logic [N-1:0] g_hot;

  always @(negedge clk) begin
    if (p_rst) begin
      check("reset_outputs", {bus.grant, bus.done, bus.busy, bus.led}, 0);
      in_g = 0;
      zero_run = 0;
    end else begin
      if (p_done != '0) check("done_single_cycle", bus.done, 0);
      if (bus.grant != '0 && !in_g) begin
        check("expected_queue_nonempty", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          cur = expq.pop_front();
          check("grant_index", bus.grant, 1 << cur.idx);
          if (cur.pre >= 0) check("grant_spacing", zero_run, cur.pre);
        end else begin
          cur = '{-1, 0, -1};
        end
        in_g = 1; glen = 0; led_err = 0; busy_err = 0;
        g_hot = bus.grant;
      end
      if (in_g && bus.grant != '0) begin
        if (bus.led !== ((glen < cur.code * PULSE) && ((glen % PULSE) < ON * DIV))) led_err++;
        if (bus.busy !== 1'b1 || bus.grant !== g_hot) busy_err++;
        glen++;
      end
      if (bus.grant == '0) zero_run++;
      if (bus.done != '0) begin
        check("done_while_granted", in_g, 1);
        if (in_g) begin
          check("done_index", bus.done, g_hot);
          check("grant_length", glen, cur.code * PULSE + GAP * DIV);
          check("led_pattern_errors", led_err, 0);
          check("busy_grant_stable_errors", busy_err, 0);
          check("done_cycle_outputs", {bus.grant, bus.busy, bus.led}, 0);
        end
        in_g = 0;
        zero_run = 1;
      end
      if (bus.grant == '0 && bus.done == '0 && p_grant == '0 && p_done == '0)
        check("idle_follow", {bus.led, bus.busy}, {p_idle, 1'b0});
    end
    if (end_req && !mon_fin) begin
      check("queue_empty_at_end", expq.size(), 0);
      check("no_grant_at_end", in_g, 0);
      mon_fin = 1;
    end
    p_rst  = rst;
    p_grant = bus.grant;
    p_done = bus.done;
    p_idle = bus.idle_led;
  end

  task automatic set_code(input int i, input int v);
    codes[i] = v;
    bus.code[i*CW +: CW] = CW'(v);
  endtask

  task automatic wait_grant();
    int cyc = 0;
    while (bus.grant == '0) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 5000) begin
        $display("FAIL wait_grant: no grant after %0d cycles", cyc);
        $fatal(1, "grant timeout");
      end
    end
  endtask

  task automatic wait_dones(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n) begin
      @(posedge clk); #1;
      if (bus.done != '0) seen++;
      cyc++;
      if (cyc > 20000) begin
        $display("FAIL wait_dones: seen %0d of %0d", seen, n);
        $fatal(1, "done timeout");
      end
    end
  endtask

  task automatic serve(input logic [N-1:0] mask, input int n);
    for (int j = 0; j < n; j++) begin
      int idx;
      idx = rr_pick(mask, model_ptr);
      expq.push_back('{idx, codes[idx], (j == 0) ? -1 : 1});
      model_ptr = (idx + 1) % N;
    end
    bus.req = mask;
    wait_dones(n);
    bus.req = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      bus.idle_led = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    bus.req = '0;
    bus.code = '0;
    bus.idle_led = 1'b0;
    for (int i = 0; i < N; i++) codes[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Every requester held, code 1: back-to-back round robin 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_code(i, 1);
    serve(4'b1111, 5);
    idle_cycles(4);

    // Reset while req[0] is in its ON phase, then regrant.
    set_code(0, 3);
    expq.push_back('{0, 3, -1});
    bus.req = 4'b0001;
    wait_grant();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
    expq.push_back('{0, 3, 0});
    model_ptr = 1;
    wait_dones(1);
    bus.req = '0;

    idle_cycles(20);

    set_code(1, 3);
    serve(4'b0010, 1);
    idle_cycles(3);

    set_code(2, 0);
    serve(4'b0100, 1);
    idle_cycles(3);

    // Code rewritten one cycle into the grant must not change the pulse count.
    set_code(1, 2);
    expq.push_back('{rr_pick(4'b0010, model_ptr), 2, -1});
    model_ptr = 2;
    bus.req = 4'b0010;
    wait_grant();
    @(posedge clk); #1;
    bus.code[1*CW +: CW] = CW'(7);
    wait_dones(1);
    bus.req = '0;
    set_code(1, 7);
    idle_cycles(3);

    for (int r = 0; r < 8; r++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) set_code(i, int'($urandom_range(0, 15)));
      serve(mask, int'($urandom_range(1, 3)));
      idle_cycles(int'($urandom_range(3, 8)));
    end

    end_req = 1;
    repeat (3) @(posedge clk);
    if (!mon_fin) begin
      $display("FAIL monitor_final: monitor did not finish");
      $fatal(1, "monitor stalled");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
